// File: rtl/aip_prefix_sum_slave_if.sv
// Controller-to-slave strobe bundle for one AIP slave port.
interface aip_prefix_sum_slave_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned CONF_WIDTH = 5
);
    logic [DATA_WIDTH-1:0] i_dataInAIP;
    logic [CONF_WIDTH-1:0] i_configAIP;
    logic                  i_writeAIP;
    logic                  i_readAIP;
    logic                  i_start;
    logic [DATA_WIDTH-1:0] o_dataOutAIP;
    logic                  o_int;

    // Controller side drives strobes and samples results.
    modport master (
        output i_dataInAIP, i_configAIP, i_writeAIP, i_readAIP, i_start,
        input  o_dataOutAIP, o_int
    );

    // Slave core side.
    modport slave (
        input  i_dataInAIP, i_configAIP, i_writeAIP, i_readAIP, i_start,
        output o_dataOutAIP, o_int
    );
endinterface

// File: rtl/aip_prefix_sum_slave.sv
// AIP slave core: buffers up to DEPTH words, computes running sums on start,
// exposes results through MDATAOUT reads and raises a level interrupt when done.
module aip_prefix_sum_slave #(
    parameter int unsigned           DATA_WIDTH = 32,
    parameter int unsigned           CONF_WIDTH = 5,
    parameter int unsigned           DEPTH      = 16,
    parameter logic [DATA_WIDTH-1:0] IP_ID      = DATA_WIDTH'(32'h0000_5A01)
) (
    input  logic                 i_clk,
    input  logic                 i_rst_a,
    aip_prefix_sum_slave_if.slave bus
);
    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = IDX_W + 1;

    localparam logic [CONF_WIDTH-1:0] CFG_DIN  = CONF_WIDTH'(5'h00);
    localparam logic [CONF_WIDTH-1:0] CFG_DOUT = CONF_WIDTH'(5'h01);
    localparam logic [CONF_WIDTH-1:0] CFG_STAT = CONF_WIDTH'(5'h1E);
    localparam logic [CONF_WIDTH-1:0] CFG_ID   = CONF_WIDTH'(5'h1F);

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [DATA_WIDTH-1:0] in_buf  [DEPTH];
    logic [DATA_WIDTH-1:0] out_buf [DEPTH];

    logic [CNT_W-1:0]      in_cnt_q, out_cnt_q, rd_ptr_q;
    logic [IDX_W-1:0]      idx_q;
    logic [DATA_WIDTH-1:0] acc_q, data_out_q;
    logic                  ovf_q, busy_err_q, udf_q, int_q;

    logic                  wr_din, wr_stat, din_ok;
    logic                  start_go, run_last;
    logic                  rd_adv, rd_udf;
    logic [DATA_WIDTH-1:0] sum, rd_data, status;

    assign wr_din  = bus.i_writeAIP && (bus.i_configAIP == CFG_DIN);
    assign wr_stat = bus.i_writeAIP && (bus.i_configAIP == CFG_STAT);
    assign din_ok  = wr_din && (state_q != ST_RUN) && (in_cnt_q != CNT_FULL);
    assign sum     = acc_q + in_buf[idx_q];

    assign bus.o_dataOutAIP = data_out_q;
    assign bus.o_int        = int_q;

    // Status word assembly.
    always_comb begin
        status        = '0;
        status[0]     = (state_q == ST_DONE);
        status[1]     = (state_q == ST_RUN);
        status[2]     = ovf_q;
        status[3]     = busy_err_q;
        status[4]     = udf_q;
        status[12:8]  = 5'(in_cnt_q);
        status[20:16] = 5'(out_cnt_q);
    end

    // Read mux; MDATAOUT reads are bounded by the results produced so far.
    always_comb begin
        rd_data = '0;
        rd_adv  = 1'b0;
        rd_udf  = 1'b0;
        if (bus.i_readAIP) begin
            case (bus.i_configAIP)
                CFG_DOUT: begin
                    if (rd_ptr_q < out_cnt_q) begin
                        rd_data = out_buf[rd_ptr_q[IDX_W-1:0]];
                        rd_adv  = 1'b1;
                    end else begin
                        rd_udf  = 1'b1;
                    end
                end
                CFG_STAT: rd_data = status;
                CFG_ID:   rd_data = IP_ID;
                default:  rd_data = '0;
            endcase
        end
    end

    // Next-state logic for IDLE/RUN/DONE.
    always_comb begin
        state_d  = state_q;
        start_go = 1'b0;
        run_last = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (bus.i_start) begin
                    start_go = 1'b1;
                    state_d  = (in_cnt_q == '0) ? ST_DONE : ST_RUN;
                end else if ((state_q == ST_DONE) && wr_stat && bus.i_dataInAIP[0]) begin
                    state_d  = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (CNT_W'(idx_q) == (in_cnt_q - CNT_ONE)) begin
                    run_last = 1'b1;
                    state_d  = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge i_clk or posedge i_rst_a) begin
        if (i_rst_a) state_q <= ST_IDLE;
        else         state_q <= state_d;
    end

    // Counters, accumulator, sticky flags, read data and interrupt.
    always_ff @(posedge i_clk or posedge i_rst_a) begin
        if (i_rst_a) begin
            in_cnt_q   <= '0;
            out_cnt_q  <= '0;
            rd_ptr_q   <= '0;
            idx_q      <= '0;
            acc_q      <= '0;
            data_out_q <= '0;
            ovf_q      <= 1'b0;
            busy_err_q <= 1'b0;
            udf_q      <= 1'b0;
            int_q      <= 1'b0;
        end else begin
            if (bus.i_readAIP) data_out_q <= rd_data;
            if (rd_adv)        rd_ptr_q   <= rd_ptr_q + CNT_ONE;

            // Clears first so that a same-cycle error event still sticks.
            if (wr_stat && bus.i_dataInAIP[1]) begin
                ovf_q      <= 1'b0;
                busy_err_q <= 1'b0;
                udf_q      <= 1'b0;
            end
            if (wr_stat && bus.i_dataInAIP[0]) int_q <= 1'b0;

            if (rd_udf) udf_q <= 1'b1;
            if (wr_din && (state_q == ST_RUN)) busy_err_q <= 1'b1;
            if (wr_din && (state_q != ST_RUN) && (in_cnt_q == CNT_FULL)) ovf_q <= 1'b1;
            if (din_ok) in_cnt_q <= in_cnt_q + CNT_ONE;

            if (start_go) begin
                acc_q     <= '0;
                idx_q     <= '0;
                out_cnt_q <= '0;
                rd_ptr_q  <= '0;
                int_q     <= (in_cnt_q == '0);
            end

            if (state_q == ST_RUN) begin
                acc_q     <= sum;
                idx_q     <= idx_q + IDX_ONE;
                out_cnt_q <= CNT_W'(idx_q) + CNT_ONE;
            end

            if (run_last) begin
                int_q    <= 1'b1;
                in_cnt_q <= '0;
            end
        end
    end

    // Input buffer capture; contents are only ever read below in_cnt.
    always_ff @(posedge i_clk) begin
        if (din_ok) in_buf[in_cnt_q[IDX_W-1:0]] <= bus.i_dataInAIP;
    end

    // Result buffer; contents are only ever read below out_cnt.
    always_ff @(posedge i_clk) begin
        if (state_q == ST_RUN) out_buf[idx_q] <= sum;
    end
endmodule

// File: tb/tb_aip_prefix_sum_slave.sv
// Bench for aip_prefix_sum_slave: constant vector table, directed corner
// sequences and randomized loads checked against a queue-based model.
module tb_aip_prefix_sum_slave;
    localparam int unsigned DW    = 32;
    localparam int unsigned CW    = 5;
    localparam int unsigned DEPTH = 16;

    localparam logic [4:0] A_DIN  = 5'h00;
    localparam logic [4:0] A_DOUT = 5'h01;
    localparam logic [4:0] A_STAT = 5'h1E;
    localparam logic [4:0] A_ID   = 5'h1F;

    logic clk = 1'b0;
    logic rst;

    aip_prefix_sum_slave_if #(.DATA_WIDTH(DW), .CONF_WIDTH(CW)) bus ();

    aip_prefix_sum_slave #(
        .DATA_WIDTH(DW), .CONF_WIDTH(CW), .DEPTH(DEPTH), .IP_ID(32'h0000_5A01)
    ) dut (
        .i_clk  (clk),
        .i_rst_a(rst),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: loaded words, produced sums, read pointer, flags.
    logic [31:0] in_q[$];
    logic [31:0] out_q[$];
    logic [31:0] pend_q[$];
    int          m_state;   // 0 idle, 1 run, 2 done
    int          m_rd;
    logic        m_ovf, m_berr, m_udf, m_int;

    function automatic void m_reset();
        in_q.delete(); out_q.delete(); pend_q.delete();
        m_state = 0; m_rd = 0;
        m_ovf = 0; m_berr = 0; m_udf = 0; m_int = 0;
    endfunction

    function automatic logic [31:0] m_status();
        logic [31:0] s;
        s        = '0;
        s[0]     = (m_state == 2);
        s[1]     = (m_state == 1);
        s[2]     = m_ovf;
        s[3]     = m_berr;
        s[4]     = m_udf;
        s[12:8]  = 5'(in_q.size());
        s[20:16] = 5'(out_q.size());
        return s;
    endfunction

    function automatic void m_din(input logic [31:0] d);
        if (m_state == 1)              m_berr = 1;
        else if (in_q.size() == DEPTH) m_ovf  = 1;
        else                           in_q.push_back(d);
    endfunction

    function automatic void m_stat_wr(input logic [31:0] d);
        if (d[1]) begin m_ovf = 0; m_berr = 0; m_udf = 0; end
        if (d[0]) begin m_int = 0; if (m_state == 2) m_state = 0; end
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] cfg);
        logic [31:0] r;
        r = '0;
        case (cfg)
            A_DOUT: begin
                if (m_rd < out_q.size()) begin r = out_q[m_rd]; m_rd++; end
                else m_udf = 1;
            end
            A_STAT:  r = m_status();
            A_ID:    r = 32'h0000_5A01;
            default: r = '0;
        endcase
        return r;
    endfunction

    function automatic void m_start();
        logic [31:0] a;
        if (m_state == 1) return;
        a = '0;
        pend_q.delete();
        foreach (in_q[i]) begin a = a + in_q[i]; pend_q.push_back(a); end
        out_q.delete();
        m_rd = 0;
        if (in_q.size() == 0) begin m_state = 2; m_int = 1; end
        else                  begin m_state = 1; m_int = 0; end
    endfunction

    function automatic void m_complete();
        out_q = pend_q;
        in_q.delete();
        m_state = 2;
        m_int   = 1;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [4:0] cfg, input logic [31:0] d);
        bus.i_configAIP = cfg;
        bus.i_dataInAIP = d;
        bus.i_writeAIP  = 1'b1;
        tick();
        bus.i_writeAIP  = 1'b0;
        if (cfg == A_DIN)       m_din(d);
        else if (cfg == A_STAT) m_stat_wr(d);
    endtask

    task automatic do_read(input logic [4:0] cfg, output logic [31:0] act, output logic [31:0] exp);
        exp = m_read(cfg);
        bus.i_configAIP = cfg;
        bus.i_readAIP   = 1'b1;
        tick();
        bus.i_readAIP   = 1'b0;
        act = bus.o_dataOutAIP;
    endtask

    task automatic do_start();
        bus.i_start = 1'b1;
        tick();
        bus.i_start = 1'b0;
        m_start();
    endtask

    // Counts edges until o_int rises; a stuck interrupt exhausts the bound.
    task automatic run_to_done(input int exp_edges);
        int n;
        n = 0;
        while (bus.o_int !== 1'b1 && n < 200) begin tick(); n++; end
        check("int_latency", 32'(n), 32'(exp_edges));
        if (m_state == 1) m_complete();
    endtask

    typedef struct {
        logic        wr;
        logic [4:0]  cfg;
        logic [31:0] data;
        logic [31:0] exp;
        string       name;
    } vec_t;

    vec_t tbl[10];

    initial begin
        logic [31:0] act, exp, s16;
        logic [31:0] w[17];
        int          n, nr;
        logic [31:0] ex4[4];

        tbl[0] = '{1'b1, A_DOUT, 32'hDEAD_BEEF, 32'h0,          "wr_dout_ignored"};
        tbl[1] = '{1'b1, 5'h07,  32'h1234_5678, 32'h0,          "wr_unmapped"};
        tbl[2] = '{1'b0, A_STAT, 32'h0,         32'h0000_0000,  "status_clean"};
        tbl[3] = '{1'b0, A_DOUT, 32'h0,         32'h0000_0000,  "dout_empty"};
        tbl[4] = '{1'b0, A_STAT, 32'h0,         32'h0000_0010,  "status_udf"};
        tbl[5] = '{1'b1, A_STAT, 32'h2,         32'h0,          "clear_flags"};
        tbl[6] = '{1'b0, A_STAT, 32'h0,         32'h0000_0000,  "status_cleared"};
        tbl[7] = '{1'b0, 5'h05,  32'h0,         32'h0000_0000,  "rd_cfg05"};
        tbl[8] = '{1'b0, 5'h1C,  32'h0,         32'h0000_0000,  "rd_cfg1c"};
        tbl[9] = '{1'b0, A_ID,   32'h0,         32'h0000_5A01,  "rd_id"};

        bus.i_dataInAIP = '0;
        bus.i_configAIP = '0;
        bus.i_writeAIP  = 1'b0;
        bus.i_readAIP   = 1'b0;
        bus.i_start     = 1'b0;
        rst = 1'b1;
        m_reset();
        repeat (3) tick();
        check("rst_dout", bus.o_dataOutAIP, 32'h0);
        check("rst_int", 32'(bus.o_int), 32'h0);
        rst = 1'b0;
        tick();

        // Register map vectors.
        for (int i = 0; i < 10; i++) begin
            if (tbl[i].wr) do_write(tbl[i].cfg, tbl[i].data);
            else begin
                do_read(tbl[i].cfg, act, exp);
                check(tbl[i].name, act, tbl[i].exp);
            end
        end
        repeat (3) tick();
        check("dout_hold", bus.o_dataOutAIP, 32'h0000_5A01);

        // 1,2,3,4 -> 1,3,6,10 then underflow.
        for (int i = 1; i <= 4; i++) do_write(A_DIN, 32'(i));
        do_start();
        do_read(A_STAT, act, exp);
        check("status_busy", act, 32'h0000_0402);
        run_to_done(3);
        ex4 = '{32'd1, 32'd3, 32'd6, 32'd10};
        for (int i = 0; i < 4; i++) begin
            do_read(A_DOUT, act, exp);
            check("sum4", act, ex4[i]);
        end
        do_read(A_DOUT, act, exp);
        check("sum4_past_end", act, 32'h0);
        do_read(A_STAT, act, exp);
        check("status_done_udf", act, 32'h0004_0011);
        do_write(A_STAT, 32'h3);
        check("int_cleared", 32'(bus.o_int), 32'h0);
        do_read(A_STAT, act, exp);
        check("status_after_clear", act, 32'h0004_0000);

        // 17 words into a 16-deep buffer.
        for (int i = 0; i < 17; i++) begin w[i] = $urandom; do_write(A_DIN, w[i]); end
        do_read(A_STAT, act, exp);
        check("ovf_status", act, exp);
        check("ovf_bit_cnt", {19'h0, act[12:8], 5'h0, act[2], 2'h0}, {19'h0, 5'd16, 5'h0, 1'b1, 2'h0});
        do_start();
        run_to_done(16);
        s16 = '0;
        for (int i = 0; i < 16; i++) s16 = s16 + w[i];
        for (int i = 0; i < 16; i++) begin
            do_read(A_DOUT, act, exp);
            check("ovf_sums", act, exp);
        end
        check("ovf_last_sum", act, s16);
        do_write(A_STAT, 32'h3);

        // Wraparound.
        do_write(A_DIN, 32'hFFFF_FFFF);
        do_write(A_DIN, 32'h0000_0002);
        do_start();
        run_to_done(2);
        do_read(A_DOUT, act, exp);
        check("wrap0", act, 32'hFFFF_FFFF);
        do_read(A_DOUT, act, exp);
        check("wrap1", act, 32'h0000_0001);
        do_write(A_STAT, 32'h3);

        // Empty start.
        do_start();
        run_to_done(0);
        do_read(A_STAT, act, exp);
        check("empty_status", act, 32'h0000_0001);
        do_write(A_STAT, 32'h3);
        check("empty_int_clr", 32'(bus.o_int), 32'h0);
        do_read(A_STAT, act, exp);
        check("empty_status_clr", act, 32'h0);

        // Write and restart during RUN.
        for (int i = 0; i < 8; i++) do_write(A_DIN, $urandom);
        do_start();
        do_write(A_DIN, 32'hCAFE_F00D);
        do_start();
        run_to_done(6);
        do_read(A_STAT, act, exp);
        check("berr_status", act, 32'h0008_0009);
        for (int i = 0; i < 8; i++) begin
            do_read(A_DOUT, act, exp);
            check("berr_sums", act, exp);
        end
        do_write(A_STAT, 32'h3);

        // Reset in the middle of a run.
        for (int i = 0; i < 5; i++) do_write(A_DIN, $urandom);
        do_start();
        tick();
        tick();
        rst = 1'b1;
        #1;
        check("midrun_rst_int", 32'(bus.o_int), 32'h0);
        check("midrun_rst_dout", bus.o_dataOutAIP, 32'h0);
        tick();
        rst = 1'b0;
        m_reset();
        do_read(A_STAT, act, exp);
        check("midrun_rst_status", act, 32'h0);

        // Randomized loads against the model.
        for (int it = 0; it < 12; it++) begin
            n = $urandom_range(0, DEPTH + 2);
            for (int i = 0; i < n; i++)
                do_write(A_DIN, ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 15)) : $urandom);
            do_read(A_STAT, act, exp);
            check("rnd_status_pre", act, exp);
            do_start();
            run_to_done((n > DEPTH) ? DEPTH : n);
            nr = $urandom_range(0, ((n > DEPTH) ? DEPTH : n) + 1);
            for (int i = 0; i < nr; i++) begin
                do_read(A_DOUT, act, exp);
                check("rnd_sum", act, exp);
            end
            do_read(A_STAT, act, exp);
            check("rnd_status_post", act, exp);
            do_write(A_STAT, 32'($urandom_range(0, 3)));
            check("rnd_int", 32'(bus.o_int), 32'(m_int));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
